// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use hazard bubble insertion and bubble counter
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              id_valid_i,
    input  logic [7:0]        id_aluop_i,
    input  logic [5:0]        id_funct_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_uses_rt_i,
    input  logic [DATA_W-1:0] id_rs_data_i,
    input  logic [DATA_W-1:0] id_rt_data_i,
    input  logic [DATA_W-1:0] id_imm_i,
    input  logic [6:0]        id_ctrl_i,
    output logic              ex_valid_o,
    output logic [7:0]        ex_aluop_o,
    output logic [5:0]        ex_funct_o,
    output logic [REG_AW-1:0] ex_rs_o,
    output logic [REG_AW-1:0] ex_rt_o,
    output logic [REG_AW-1:0] ex_rd_o,
    output logic [DATA_W-1:0] ex_rs_data_o,
    output logic [DATA_W-1:0] ex_rt_data_o,
    output logic [DATA_W-1:0] ex_imm_o,
    output logic [6:0]        ex_ctrl_o,
    output logic              stall_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    // ctrl packing {regwrite,memread,memwrite,memtoreg,alusrc,regdst,branch}
    localparam int CTRL_MEMREAD = 5;

    // Bubble funct is ADD so the ALU controller decodes a harmless add, never the undefined code
    localparam logic [5:0] BUBBLE_FUNCT = 6'h20;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic hazard;
    logic load_bubble;
    logic load_id;
    logic count_en;

    // Load-use detection: a load in EX whose destination is read by the instruction in ID
    always_comb begin
        hazard = ex_valid_o
               & ex_ctrl_o[CTRL_MEMREAD]
               & (ex_rt_o != '0)
               & id_valid_i
               & ((ex_rt_o == id_rs_i) | (id_uses_rt_i & (ex_rt_o == id_rt_i)));
    end

    assign stall_o = stall_i | hazard;

    // Per-edge action select: flush beats stall beats hazard beats normal capture
    always_comb begin
        load_bubble = 1'b0;
        load_id     = 1'b0;
        count_en    = 1'b0;
        if (flush_i) begin
            load_bubble = 1'b1;
            count_en    = 1'b1;
        end else if (stall_i) begin
            load_bubble = 1'b0;
        end else if (hazard) begin
            load_bubble = 1'b1;
            count_en    = 1'b1;
        end else if (id_valid_i) begin
            load_id = 1'b1;
        end else begin
            // Empty ID slot becomes a bubble but is not a hazard bubble, so it is not counted
            load_bubble = 1'b1;
        end
    end

    // EX register: bubble on reset/flush/hazard/empty slot, capture ID otherwise, hold on stall
    always_ff @(posedge clk_i) begin
        if (!rst_i || load_bubble) begin
            ex_valid_o   <= 1'b0;
            ex_aluop_o   <= 8'h00;
            ex_funct_o   <= BUBBLE_FUNCT;
            ex_rs_o      <= '0;
            ex_rt_o      <= '0;
            ex_rd_o      <= '0;
            ex_rs_data_o <= '0;
            ex_rt_data_o <= '0;
            ex_imm_o     <= '0;
            ex_ctrl_o    <= 7'b0;
        end else if (load_id) begin
            ex_valid_o   <= id_valid_i;
            ex_aluop_o   <= id_aluop_i;
            ex_funct_o   <= id_funct_i;
            ex_rs_o      <= id_rs_i;
            ex_rt_o      <= id_rt_i;
            ex_rd_o      <= id_rd_i;
            ex_rs_data_o <= id_rs_data_i;
            ex_rt_data_o <= id_rt_data_i;
            ex_imm_o     <= id_imm_i;
            ex_ctrl_o    <= id_ctrl_i;
        end
    end

    // Saturating bubble counter: sticks at all-ones rather than wrapping
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            bubble_cnt_o <= '0;
        end else if (count_en && (bubble_cnt_o != CNT_MAX)) begin
            bubble_cnt_o <= bubble_cnt_o + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - table-driven self-checking bench for id_ex_stage
module tb_id_ex_stage;

    typedef struct packed {
        logic        valid;
        logic [7:0]  aluop;
        logic [5:0]  funct;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        uses_rt;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [6:0]  ctrl;
    } instr_t;

    typedef struct {
        logic   flush;
        logic   stall;
        instr_t id;
        logic   exp_stall;
        instr_t exp_ex;
        int     exp_cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        id_valid = 1'b0;
    logic [7:0]  id_aluop = '0;
    logic [5:0]  id_funct = '0;
    logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0;
    logic        id_uses_rt = 1'b0;
    logic [31:0] id_rs_data = '0, id_rt_data = '0, id_imm = '0;
    logic [6:0]  id_ctrl = '0;

    logic        ex_valid;
    logic [7:0]  ex_aluop;
    logic [5:0]  ex_funct;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic [31:0] ex_rs_data, ex_rt_data, ex_imm;
    logic [6:0]  ex_ctrl;
    logic        stall_out;
    logic [15:0] cnt;

    logic        q_valid;
    logic [7:0]  q_aluop;
    logic [5:0]  q_funct;
    logic [4:0]  q_rs, q_rt, q_rd;
    logic [31:0] q_rs_data, q_rt_data, q_imm;
    logic [6:0]  q_ctrl;
    logic        q_stall;
    logic [3:0]  q_cnt;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
        .id_valid_i(id_valid), .id_aluop_i(id_aluop), .id_funct_i(id_funct),
        .id_rs_i(id_rs), .id_rt_i(id_rt), .id_rd_i(id_rd), .id_uses_rt_i(id_uses_rt),
        .id_rs_data_i(id_rs_data), .id_rt_data_i(id_rt_data), .id_imm_i(id_imm), .id_ctrl_i(id_ctrl),
        .ex_valid_o(ex_valid), .ex_aluop_o(ex_aluop), .ex_funct_o(ex_funct),
        .ex_rs_o(ex_rs), .ex_rt_o(ex_rt), .ex_rd_o(ex_rd),
        .ex_rs_data_o(ex_rs_data), .ex_rt_data_o(ex_rt_data), .ex_imm_o(ex_imm), .ex_ctrl_o(ex_ctrl),
        .stall_o(stall_out), .bubble_cnt_o(cnt)
    );

    id_ex_stage #(.CNT_W(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
        .id_valid_i(id_valid), .id_aluop_i(id_aluop), .id_funct_i(id_funct),
        .id_rs_i(id_rs), .id_rt_i(id_rt), .id_rd_i(id_rd), .id_uses_rt_i(id_uses_rt),
        .id_rs_data_i(id_rs_data), .id_rt_data_i(id_rt_data), .id_imm_i(id_imm), .id_ctrl_i(id_ctrl),
        .ex_valid_o(q_valid), .ex_aluop_o(q_aluop), .ex_funct_o(q_funct),
        .ex_rs_o(q_rs), .ex_rt_o(q_rt), .ex_rd_o(q_rd),
        .ex_rs_data_o(q_rs_data), .ex_rt_data_o(q_rt_data), .ex_imm_o(q_imm), .ex_ctrl_o(q_ctrl),
        .stall_o(q_stall), .bubble_cnt_o(q_cnt)
    );

    function automatic instr_t mk(input logic v, input logic [7:0] op, input logic [5:0] fn,
                                  input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                  input logic urt, input logic [31:0] rsd, input logic [31:0] rtd,
                                  input logic [31:0] imm, input logic [6:0] ctrl);
        instr_t r;
        r.valid = v; r.aluop = op; r.funct = fn; r.rs = rs; r.rt = rt; r.rd = rd;
        r.uses_rt = urt; r.rs_data = rsd; r.rt_data = rtd; r.imm = imm; r.ctrl = ctrl;
        return r;
    endfunction

    function automatic instr_t strip(input instr_t x);
        instr_t r;
        r = x;
        r.uses_rt = 1'b0;
        return r;
    endfunction

    function automatic instr_t ex_now();
        return mk(ex_valid, ex_aluop, ex_funct, ex_rs, ex_rt, ex_rd, 1'b0,
                  ex_rs_data, ex_rt_data, ex_imm, ex_ctrl);
    endfunction

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic st, input instr_t id);
        flush = fl; stall = st;
        id_valid = id.valid; id_aluop = id.aluop; id_funct = id.funct;
        id_rs = id.rs; id_rt = id.rt; id_rd = id.rd; id_uses_rt = id.uses_rt;
        id_rs_data = id.rs_data; id_rt_data = id.rt_data; id_imm = id.imm; id_ctrl = id.ctrl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[$];

    task automatic add(input logic fl, input logic st, input instr_t id,
                       input logic es, input instr_t ee, input int ec);
        vec_t v;
        v.flush = fl; v.stall = st; v.id = id; v.exp_stall = es; v.exp_ex = strip(ee); v.exp_cnt = ec;
        vecs.push_back(v);
    endtask

    instr_t BUB, ADDI, LW4, ADD4, SWN, SWU, LW0, ADD0, INV, BEQ;

    initial begin
        BUB  = mk(0, 8'h00, 6'h20, 0, 0, 0, 0, 32'h0,    32'h0,    32'h0,        7'b0000000);
        ADDI = mk(1, 8'h08, 6'h00, 3, 7, 0, 0, 32'h11,   32'h22,   32'h5,        7'b1000100);
        LW4  = mk(1, 8'h23, 6'h00, 1, 4, 0, 0, 32'h100,  32'h0,    32'h8,        7'b1101100);
        ADD4 = mk(1, 8'h00, 6'h20, 4, 5, 6, 1, 32'h33,   32'h44,   32'h0,        7'b1000010);
        SWN  = mk(1, 8'h2B, 6'h00, 2, 4, 0, 0, 32'h200,  32'h55,   32'hC,        7'b0010100);
        SWU  = mk(1, 8'h2B, 6'h00, 2, 4, 0, 1, 32'h200,  32'h55,   32'hC,        7'b0010100);
        LW0  = mk(1, 8'h23, 6'h00, 1, 0, 0, 0, 32'h300,  32'h0,    32'h10,       7'b1101100);
        ADD0 = mk(1, 8'h00, 6'h20, 0, 0, 9, 1, 32'h1,    32'h2,    32'h0,        7'b1000010);
        INV  = mk(0, 8'h23, 6'h3F, 4, 4, 4, 1, 32'hDEAD, 32'hBEEF, 32'h1,        7'b1111111);
        BEQ  = mk(1, 8'h04, 6'h00, 1, 2, 0, 1, 32'h7,    32'h7,    32'hFFFFFFFC, 7'b0000001);

        //  flush stall id    stall_o ex    cnt
        add(0, 0, ADDI, 0, ADDI, 0);
        add(0, 0, LW4,  0, LW4,  0);
        add(0, 0, ADD4, 1, BUB,  1);
        add(0, 0, ADD4, 0, ADD4, 1);
        add(0, 0, LW4,  0, LW4,  1);
        add(0, 0, SWN,  0, SWN,  1);
        add(0, 0, LW4,  0, LW4,  1);
        add(0, 1, ADD4, 1, LW4,  1);
        add(0, 0, SWU,  1, BUB,  2);
        add(0, 0, SWU,  0, SWU,  2);
        add(0, 0, LW0,  0, LW0,  2);
        add(0, 0, ADD0, 0, ADD0, 2);
        add(0, 0, INV,  0, BUB,  2);
        add(0, 0, BEQ,  0, BEQ,  2);
        add(1, 1, ADDI, 1, BUB,  3);
        add(0, 0, ADDI, 0, ADDI, 3);
        add(0, 1, LW4,  1, ADDI, 3);
        add(0, 1, LW4,  1, ADDI, 3);
        add(0, 1, LW4,  1, ADDI, 3);
        add(1, 0, LW4,  0, BUB,  4);

        // Reset for two edges with random ID inputs
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive($urandom_range(0, 1), $urandom_range(0, 1),
                  mk(1'b1, 8'($urandom), 6'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                     1'b1, $urandom, $urandom, $urandom, 7'($urandom)));
            tick();
        end
        chk("reset_ex", 160'(ex_now()), 160'(BUB));
        chk("reset_cnt", 160'(cnt), 160'(0));
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].flush, vecs[i].stall, vecs[i].id);
            #1;
            chk($sformatf("v%0d_stall", i), 160'(stall_out), 160'(vecs[i].exp_stall));
            tick();
            chk($sformatf("v%0d_ex", i), 160'(ex_now()), 160'(vecs[i].exp_ex));
            chk($sformatf("v%0d_cnt", i), 160'(cnt), 160'(vecs[i].exp_cnt));
        end

        // Reset arriving while stalled with a load in EX
        drive(0, 0, LW4);
        tick();
        chk("pre_rst_ex", 160'(ex_now()), 160'(strip(LW4)));
        drive(0, 1, ADD4);
        rst = 1'b0;
        #1;
        chk("pre_rst_stall", 160'(stall_out), 160'(1));
        tick();
        chk("midstall_rst_ex", 160'(ex_now()), 160'(BUB));
        chk("midstall_rst_cnt", 160'(cnt), 160'(0));
        rst = 1'b1;
        #1;
        chk("post_rst_stall_hi", 160'(stall_out), 160'(1));
        stall = 1'b0;
        #1;
        chk("post_rst_stall_lo", 160'(stall_out), 160'(0));

        // Twenty load-use hazards: wide counter reaches 20, 4-bit counter sticks at F
        for (int i = 0; i < 20; i++) begin
            drive(0, 0, LW4);
            tick();
            drive(0, 0, ADD4);
            #1;
            chk($sformatf("sat_hz%0d_stall", i), 160'(stall_out), 160'(1));
            tick();
            if (i == 14) chk("sat_cnt4_at15", 160'(q_cnt), 160'(4'hF));
            if (i == 15) chk("sat_cnt4_at16", 160'(q_cnt), 160'(4'hF));
        end
        chk("sat_cnt16", 160'(cnt), 160'(20));
        chk("sat_cnt4", 160'(q_cnt), 160'(4'hF));
        chk("sat_ex_bubble", 160'(ex_now()), 160'(BUB));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
